// File: rtl/dram_axi_master.sv
// dram_axi_master
// ---------------------------------------------------------------------------
// Single-beat initiator for the pseudo-DRAM bus. It takes one host command
// (read or write of one DATA_W word at a word address) and runs it as an
// AR/R or AW/W/B handshake sequence on the DRAM-side channels. Completion is
// reported to the host as a one-cycle out_valid pulse carrying the read data,
// the bus response and the accept-to-completion cycle count. Out-of-range
// addresses are rejected with response 2'b11 and never reach the bus.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     host command handshake (in_ready high only in IDLE)
//   in_write              1 = write, 0 = read
//   in_addr, in_wdata     word address and write data
//   out_valid             one-cycle completion pulse
//   out_data, out_resp    read data / captured response (zero when idle)
//   out_cycles            saturating accept-to-completion cycle count
//   err_timeout           sticky: some handshake waited TIMEOUT cycles
//   AR_*, R_*             read address / read data channels
//   AW_*, W_*, B_*        write address / write data / write response channels
//
// Every output is a register. Outputs are loaded from the decode of the next
// state, so in any cycle they reflect the state the FSM is currently in.
// ---------------------------------------------------------------------------
module dram_axi_master #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int ADDR_MAX = 8191,
  parameter int TIMEOUT  = 100,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_resp,
  output logic [CNT_W-1:0]  out_cycles,
  output logic              err_timeout,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  output logic              R_READY,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              AW_VALID,
  output logic [ADDR_W-1:0] AW_ADDR,
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  output logic              B_READY,
  input  logic              AW_READY,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [WAIT_W-1:0] wait_r;
  logic              accept_s;
  logic              hs_state_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic [1:0]        done_resp_s;

  // Next-state decode; a handshake completes when our VALID/READY and the
  // slave's READY/VALID are both high at the sampling edge.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (in_addr > ADDR_W'(ADDR_MAX)) begin
            state_next_s = ST_DONE;
          end else if (in_write) begin
            state_next_s = ST_AW;
          end else begin
            state_next_s = ST_AR;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (AR_VALID && AR_READY) begin
          state_next_s = ST_R;
        end else begin
          state_next_s = ST_AR;
        end
      end
      ST_R: begin
        if (R_VALID && R_READY) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_R;
        end
      end
      ST_AW: begin
        if (AW_VALID && AW_READY) begin
          state_next_s = ST_W;
        end else begin
          state_next_s = ST_AW;
        end
      end
      ST_W: begin
        if (W_VALID && W_READY) begin
          state_next_s = ST_B;
        end else begin
          state_next_s = ST_W;
        end
      end
      ST_B: begin
        if (B_VALID && B_READY) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_B;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Datapath helpers: address to present on entry to AR/AW, the cycle count
  // for the coming cycle (the accept cycle is 1, so the first busy cycle is 2),
  // the set of states that can time out, and the response to report.
  always_comb begin
    cmd_addr_s  = addr_r;
    cnt_next_s  = cnt_r;
    hs_state_s  = 1'b0;
    done_resp_s = 2'b11;
    if (state_r == ST_IDLE) begin
      cmd_addr_s = in_addr;
      cnt_next_s = CNT_W'(2);
    end else begin
      cmd_addr_s = addr_r;
      if (&cnt_r) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end
    case (state_r)
      ST_AR, ST_R, ST_AW, ST_W, ST_B: hs_state_s = 1'b1;
      default:                        hs_state_s = 1'b0;
    endcase
    case (state_r)
      ST_R:    done_resp_s = R_RESP;
      ST_B:    done_resp_s = B_RESP;
      default: done_resp_s = 2'b11;
    endcase
  end

  // State, command capture, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      wait_r      <= {WAIT_W{1'b0}};
      err_timeout <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= {DATA_W{1'b0}};
      out_resp    <= 2'b00;
      out_cycles  <= {CNT_W{1'b0}};
      AR_VALID    <= 1'b0;
      AR_ADDR     <= {ADDR_W{1'b0}};
      R_READY     <= 1'b0;
      AW_VALID    <= 1'b0;
      AW_ADDR     <= {ADDR_W{1'b0}};
      W_VALID     <= 1'b0;
      W_DATA      <= {DATA_W{1'b0}};
      B_READY     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        addr_r  <= in_addr;
        wdata_r <= in_wdata;
      end
      // Wait counter restarts on every state change and parks at TIMEOUT.
      if (state_next_s != state_r) begin
        wait_r <= {WAIT_W{1'b0}};
      end else if (wait_r != WAIT_W'(TIMEOUT)) begin
        wait_r <= wait_r + WAIT_W'(1);
      end
      err_timeout <= err_timeout | (hs_state_s && (wait_r == WAIT_W'(TIMEOUT)));

      in_ready  <= (state_next_s == ST_IDLE);
      AR_VALID  <= (state_next_s == ST_AR);
      AR_ADDR   <= (state_next_s == ST_AR) ? cmd_addr_s : {ADDR_W{1'b0}};
      R_READY   <= (state_next_s == ST_R);
      AW_VALID  <= (state_next_s == ST_AW);
      AW_ADDR   <= (state_next_s == ST_AW) ? cmd_addr_s : {ADDR_W{1'b0}};
      W_VALID   <= (state_next_s == ST_W);
      W_DATA    <= (state_next_s == ST_W) ? wdata_r : {DATA_W{1'b0}};
      B_READY   <= (state_next_s == ST_B);

      out_valid  <= (state_next_s == ST_DONE);
      out_data   <= ((state_next_s == ST_DONE) && (state_r == ST_R)) ? R_DATA : {DATA_W{1'b0}};
      out_resp   <= (state_next_s == ST_DONE) ? done_resp_s : 2'b00;
      out_cycles <= (state_next_s == ST_DONE) ? cnt_next_s : {CNT_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_dram_axi_master.sv
// Directed bench for dram_axi_master. The initial block plays host and DRAM
// slave; a negedge monitor checks bus rules every cycle and pops expected
// completions from a scoreboard queue filled when commands are issued.
module tb_dram_axi_master;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_write;
  logic [31:0] in_addr;
  logic [63:0] in_wdata;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_resp;
  logic [15:0] out_cycles;
  logic        err_timeout;
  logic        AR_VALID;
  logic [31:0] AR_ADDR;
  logic        R_READY;
  logic        AR_READY;
  logic        R_VALID;
  logic [63:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        AW_VALID;
  logic [31:0] AW_ADDR;
  logic        W_VALID;
  logic [63:0] W_DATA;
  logic        B_READY;
  logic        AW_READY;
  logic        W_READY;
  logic        B_VALID;
  logic [1:0]  B_RESP;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic [15:0] cycles;
  } exp_t;

  exp_t             sb[$];
  bit   [63:0]      mem [bit [31:0]];
  int               compared = 0;
  int               mismatched = 0;

  logic        prev_rst = 1'b0;
  logic        prev_ar_pend = 1'b0;
  logic        prev_aw_pend = 1'b0;
  logic        prev_w_pend = 1'b0;
  logic [31:0] prev_ar_addr = 32'd0;
  logic [31:0] prev_aw_addr = 32'd0;
  logic [63:0] prev_w_data = 64'd0;

  dram_axi_master dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_write(in_write), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_resp(out_resp),
    .out_cycles(out_cycles), .err_timeout(err_timeout),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .R_READY(R_READY),
    .AR_READY(AR_READY), .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .W_VALID(W_VALID), .W_DATA(W_DATA),
    .B_READY(B_READY), .AW_READY(AW_READY), .W_READY(W_READY), .B_VALID(B_VALID),
    .B_RESP(B_RESP)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus-rule monitor and scoreboard consumer, sampled 1 time unit after negedge.
  always @(negedge clk) begin
    #1;
    if (!AR_VALID) chk("ar_addr_idle", {32'd0, AR_ADDR}, 64'd0);
    if (!AW_VALID) chk("aw_addr_idle", {32'd0, AW_ADDR}, 64'd0);
    if (!W_VALID)  chk("w_data_idle", W_DATA, 64'd0);
    if (AR_VALID)  chk("r_ready_during_ar", {63'd0, R_READY}, 64'd0);
    if (AW_VALID)  chk("w_valid_during_aw", {63'd0, W_VALID}, 64'd0);
    if (prev_rst && rst_n && prev_ar_pend) begin
      chk("ar_valid_held", {63'd0, AR_VALID}, 64'd1);
      chk("ar_addr_stable", {32'd0, AR_ADDR}, {32'd0, prev_ar_addr});
    end
    if (prev_rst && rst_n && prev_aw_pend) begin
      chk("aw_valid_held", {63'd0, AW_VALID}, 64'd1);
      chk("aw_addr_stable", {32'd0, AW_ADDR}, {32'd0, prev_aw_addr});
    end
    if (prev_rst && rst_n && prev_w_pend) begin
      chk("w_valid_held", {63'd0, W_VALID}, 64'd1);
      chk("w_data_stable", W_DATA, prev_w_data);
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_resp", {62'd0, out_resp}, {62'd0, e.resp});
        chk("out_cycles", {48'd0, out_cycles}, {48'd0, e.cycles});
      end
    end else begin
      chk("out_data_quiet", out_data, 64'd0);
      chk("out_resp_quiet", {62'd0, out_resp}, 64'd0);
    end
    prev_rst     = rst_n;
    prev_ar_pend = AR_VALID && !AR_READY;
    prev_aw_pend = AW_VALID && !AW_READY;
    prev_w_pend  = W_VALID && !W_READY;
    prev_ar_addr = AR_ADDR;
    prev_aw_addr = AW_ADDR;
    prev_w_data  = W_DATA;
  end

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [63:0] data);
    @(negedge clk);
    chk("in_ready_before_cmd", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_write = wr;
    in_addr  = addr;
    in_wdata = data;
    @(negedge clk);
    in_valid = 1'b0;
    in_write = 1'b0;
    in_addr  = 32'd0;
    in_wdata = 64'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  // Read with ar_wait cycles of AR_READY low; optional stray command mid-AR.
  task automatic do_read(input logic [31:0] addr, input int ar_wait,
                         input logic [1:0] resp, input bit inject);
    exp_t e;
    e.data   = mem.exists(addr) ? mem[addr] : 64'd0;
    e.resp   = resp;
    e.cycles = 16'(ar_wait + 4);
    sb.push_back(e);
    send_cmd(1'b0, addr, 64'd0);
    chk("ar_valid_up", {63'd0, AR_VALID}, 64'd1);
    chk("ar_addr", {32'd0, AR_ADDR}, {32'd0, addr});
    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < ar_wait; i++) begin
      if (inject && i == 0) begin
        in_valid = 1'b1;
        in_addr  = 32'h5;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_addr  = 32'd0;
    end
    AR_READY = 1'b1;
    @(negedge clk);
    AR_READY = 1'b0;
    chk("r_ready_in_r", {63'd0, R_READY}, 64'd1);
    chk("ar_valid_down", {63'd0, AR_VALID}, 64'd0);
    R_VALID = 1'b1;
    R_DATA  = mem.exists(addr) ? mem[addr] : 64'd0;
    R_RESP  = resp;
    @(negedge clk);
    R_VALID = 1'b0;
    R_DATA  = 64'd0;
    R_RESP  = 2'b00;
    drain();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [1:0] resp);
    exp_t e;
    e.data   = 64'd0;
    e.resp   = resp;
    e.cycles = 16'd5;
    sb.push_back(e);
    mem[addr] = data;
    send_cmd(1'b1, addr, data);
    chk("aw_valid_up", {63'd0, AW_VALID}, 64'd1);
    chk("aw_addr", {32'd0, AW_ADDR}, {32'd0, addr});
    AW_READY = 1'b1;
    @(negedge clk);
    AW_READY = 1'b0;
    chk("w_valid_up", {63'd0, W_VALID}, 64'd1);
    chk("w_data", W_DATA, data);
    chk("b_ready_before_w_hs", {63'd0, B_READY}, 64'd0);
    W_READY = 1'b1;
    @(negedge clk);
    W_READY = 1'b0;
    chk("b_ready_in_b", {63'd0, B_READY}, 64'd1);
    chk("w_valid_down", {63'd0, W_VALID}, 64'd0);
    B_VALID = 1'b1;
    B_RESP  = resp;
    @(negedge clk);
    B_VALID = 1'b0;
    B_RESP  = 2'b00;
    drain();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ar_valid", {63'd0, AR_VALID}, 64'd0);
    chk("rst_r_ready", {63'd0, R_READY}, 64'd0);
    chk("rst_aw_valid", {63'd0, AW_VALID}, 64'd0);
    chk("rst_w_valid", {63'd0, W_VALID}, 64'd0);
    chk("rst_b_ready", {63'd0, B_READY}, 64'd0);
    chk("rst_w_data", W_DATA, 64'd0);
    chk("rst_out_cycles", {48'd0, out_cycles}, 64'd0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    in_valid = 1'b0; in_write = 1'b0; in_addr = 32'd0; in_wdata = 64'd0;
    AR_READY = 1'b0; R_VALID = 1'b0; R_DATA = 64'd0; R_RESP = 2'b00;
    AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = 2'b00;
    mem[32'h10] = 64'h0123456789ABCDEF;
    mem[32'h20] = 64'hA5A5_5A5A_0F0F_F0F0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    chk("rst_err_timeout", {63'd0, err_timeout}, 64'd0);
    rst_n = 1'b1;

    // Basic read, write/read-back at the top legal address.
    do_read(32'h10, 0, 2'b00, 1'b0);
    do_write(32'h1FFF, 64'hDEADBEEF00000001, 2'b00);
    do_read(32'h1FFF, 2, 2'b00, 1'b0);

    // Reset while in W: no completion, buses idle, then a normal read.
    send_cmd(1'b1, 32'h40, 64'h1111_2222_3333_4444);
    AW_READY = 1'b1;
    @(negedge clk);
    AW_READY = 1'b0;
    chk("w_state_reached", {63'd0, W_VALID}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_read(32'h10, 1, 2'b00, 1'b0);

    // Range rejects: first illegal address, and a write far out of range.
    e.data = 64'd0; e.resp = 2'b11; e.cycles = 16'd2;
    sb.push_back(e);
    send_cmd(1'b0, 32'd8192, 64'd0);
    chk("reject_no_ar", {63'd0, AR_VALID}, 64'd0);
    chk("reject_no_aw", {63'd0, AW_VALID}, 64'd0);
    drain();
    sb.push_back(e);
    send_cmd(1'b1, 32'hFFFF_FFFF, 64'h1234);
    chk("reject_w_no_aw", {63'd0, AW_VALID}, 64'd0);
    drain();

    // Stray command during a busy read is ignored.
    do_read(32'h20, 3, 2'b00, 1'b1);
    repeat (5) @(negedge clk);

    // Response pass-through on both channels.
    do_read(32'h10, 0, 2'b10, 1'b0);
    do_write(32'h0, 64'hFEDC_BA98_7654_3210, 2'b01);
    do_read(32'h0, 0, 2'b00, 1'b0);
    chk("no_timeout_yet", {63'd0, err_timeout}, 64'd0);

    // Long AR stall sets the sticky timeout flag; reset clears it.
    do_read(32'h10, 120, 2'b00, 1'b0);
    chk("timeout_set", {63'd0, err_timeout}, 64'd1);
    do_write(32'h8, 64'h77, 2'b00);
    chk("timeout_sticky", {63'd0, err_timeout}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("timeout_cleared", {63'd0, err_timeout}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dram_axi_master.md
Name: dram_axi_master

Overview:
- Single-beat initiator for the pseudo-DRAM bus. It turns one host command (read or write, 64-bit word, word address) into an AR/R or AW/W/B handshake sequence on the DRAM-side channels.
- It returns the read data and response to the host through a one-cycle out_valid pulse.
- It sits between the bridge core and the DRAM model. It guarantees the DRAM-side rules: idle buses at zero, address in range, VALID and payload stable until READY, and channel ordering.

Parameters:
- ADDR_W, 32, width of AR_ADDR/AW_ADDR and in_addr
- DATA_W, 64, width of data buses
- ADDR_MAX, 8191, highest legal word address
- TIMEOUT, 100, cycles of waiting in any single handshake state before err_timeout sets
- CNT_W, 16, width of out_cycles

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  command strobe, accepted only when in_ready=1
- in_write  in  1  1=write, 0=read
- in_addr  in  ADDR_W  word address
- in_wdata  in  DATA_W  write data
- in_ready  out  1  high only in IDLE
- out_valid  out  1  one-cycle completion pulse
- out_data  out  DATA_W  read data; 0 for writes and rejects; 0 when out_valid=0
- out_resp  out  2  R_RESP/B_RESP captured; 2'b11 for range reject; 0 when out_valid=0
- out_cycles  out  CNT_W  cycles from accept to completion, saturating; valid with out_valid
- err_timeout  out  1  sticky; cleared only by reset
- AR_VALID, AR_ADDR(ADDR_W), R_READY  out  read-side master signals
- AR_READY, R_VALID, R_DATA(DATA_W), R_RESP(2)  in  read-side slave signals
- AW_VALID, AW_ADDR(ADDR_W), W_VALID, W_DATA(DATA_W), B_READY  out  write-side master signals
- AW_READY, W_READY, B_VALID, B_RESP(2)  in  write-side slave signals

Behaviour:
- Reset (rst_n=0 at a rising edge): every output is 0 except in_ready=1. The state goes to IDLE and any in-flight transaction is dropped with no completion pulse. All outputs are registered.
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - On in_valid=1 with in_addr>ADDR_MAX: go to DONE with out_resp=2'b11 and no bus activity.
  - Otherwise register the command and go to AR (read) or AW (write).
  - in_ready drops the cycle after accept.
- AR: AR_VALID=1 and AR_ADDR=registered address, both held stable until AR_VALID&&AR_READY is sampled high. R_READY stays 0 in this state. Next state: R.
- R: AR_VALID=0, AR_ADDR=0, R_READY=1. On R_VALID&&R_READY, capture R_DATA and R_RESP, drop R_READY, and go to DONE.
- AW: AW_VALID=1 and AW_ADDR held stable. W_VALID=0 and W_DATA=0 throughout. On AW handshake go to W.
- W: AW_VALID=0, AW_ADDR=0, W_VALID=1, W_DATA=registered data, held until W_READY is sampled high. Next state: B.
- B: W_VALID=0, W_DATA=0, B_READY=1. On B_VALID, capture B_RESP, drop B_READY, and go to DONE.
- DONE: out_valid=1 for exactly one cycle with out_data, out_resp and out_cycles. Next state: IDLE. in_ready returns to 1 in the following cycle.
- Idle buses: every *_ADDR and W_DATA is 0 whenever its VALID is 0.
- in_valid while in_ready=0 is ignored and not queued.
- Cycle counter: starts at 1 on the accept cycle, increments each cycle, and saturates at 2^CNT_W-1.
- Timeout:
  - A per-state wait counter resets on each state entry.
  - If the counter reaches TIMEOUT in AR, R, AW, W or B, err_timeout sets.
  - The transaction keeps waiting; VALID is never withdrawn.
- READY arriving in the same cycle VALID first rises counts as a handshake.

Test Plan:
- Preload DRAM[0x10]=64'h0123456789ABCDEF; read 0x10 -> AR_ADDR=0x10 stable until AR_READY; R_READY=0 during AR; out_valid pulse with out_data=64'h0123456789ABCDEF, out_resp=0.
- Write 0x1FFF with data 64'hDEADBEEF00000001, then read 0x1FFF -> W_VALID=0 until AW handshake; B_READY after the W handshake; read returns 64'hDEADBEEF00000001.
- Command in_addr=8192 -> no VALID ever rises; out_valid after 2 cycles with out_resp=2'b11, out_data=0.
- Pulse in_valid during a busy read with addr 0x5 -> ignored; only one completion; AR_ADDR never changes to 0x5.
- Assert rst_n=0 while in state W -> next cycle all bus outputs 0, in_ready=1, no out_valid; the following read completes normally.
- Hold AR_READY low for 120 cycles -> err_timeout=1 (sticky); AR_VALID held; completion still occurs; out_cycles>120.
